// File: rtl/round_sel_sequencer_if.sv
// Round-select bundle between the cipher controller,
// the round demultiplexer and the acknowledge return path.
interface round_sel_sequencer_if #(
  parameter int NROUNDS = 11
);
  logic               start;
  logic               stall;
  logic [NROUNDS-1:0] ack;
  logic [3:0]         SD11;
  logic               Din;
  logic               busy;
  logic               done;
  logic               err;
  logic [3:0]         err_idx;

  modport master (
    output start, stall, ack,
    input  SD11, Din, busy, done, err, err_idx
  );

  modport slave (
    input  start, stall, ack,
    output SD11, Din, busy, done, err, err_idx
  );
endinterface

// File: rtl/round_sel_sequencer.sv
// Steps round selects 0..NROUNDS-1 to the demux and checks
// each one-hot acknowledge against the select it issued.
module round_sel_sequencer #(
  parameter int NROUNDS = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  round_sel_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [3:0] LAST = 4'(NROUNDS - 1);
  localparam logic [NROUNDS-1:0] ONE = 1;

  state_e     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] sd11_q, sd11_d;
  logic       din_q, din_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [3:0] eidx_q, eidx_d;

  logic       onehot;
  logic [3:0] pos;
  logic [3:0] enc;

  always_comb begin
    pos = '0;
    for (int i = 0; i < NROUNDS; i++) begin
      if (bus.ack[i]) pos = 4'(i);
    end
  end

  // clearing the lowest set bit leaves zero only for a single bit
  assign onehot = (bus.ack != '0) &&
                  ((bus.ack & (bus.ack - ONE)) == '0);
  assign enc = onehot ? pos : 4'hF;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    eidx_d  = eidx_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          if (enc == idx_q) begin
            if (idx_q == LAST) state_d = S_DONE;
            else idx_d = idx_q + 4'd1;
          end else begin
            state_d = S_ERR;
            eidx_d  = enc;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      S_ERR: begin
        if (bus.start) begin
          state_d = S_RUN;
          idx_d   = '0;
          eidx_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // outputs are decoded from the next state so they land in registers
  always_comb begin
    sd11_d = (state_d == S_RUN) ? idx_d : 4'd0;
    din_d  = (state_d == S_RUN);
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sd11_q  <= '0;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      eidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sd11_q  <= sd11_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      eidx_q  <= eidx_d;
    end
  end

  assign bus.SD11    = sd11_q;
  assign bus.Din     = din_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.err_idx = eidx_q;
endmodule

// File: tb/tb_round_sel_sequencer.sv
// Directed bench for round_sel_sequencer with a
// cycle model compared on every falling edge.
module tb_round_sel_sequencer;
  localparam int NR = 11;

  logic clk;
  logic rst_n;
  logic force_en;
  logic [NR-1:0] force_val;

  int checks;
  int failures;

  round_sel_sequencer_if #(.NROUNDS(NR)) bus();

  round_sel_sequencer #(.NROUNDS(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // destinations answer combinationally with one-hot(SD11)
  assign bus.ack = force_en ? force_val :
                   (bus.Din ? (11'b1 << bus.SD11) : 11'b0);

  function automatic logic [11:0] outv();
    return {bus.SD11, bus.Din, bus.busy,
            bus.done, bus.err, bus.err_idx};
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic int enc_m(input logic [NR-1:0] a);
    if ($countones(a) == 1) return $clog2(a);
    return 15;
  endfunction

  bit m_run  = 0;
  int m_rnd  = 0;
  bit m_done = 0;
  bit m_err  = 0;
  int m_eidx = 0;

  always @(negedge clk) begin
    logic [11:0] ex;
    int e;
    if (!rst_n) begin
      m_run = 0; m_rnd = 0; m_done = 0;
      m_err = 0; m_eidx = 0;
    end
    ex = {(m_run ? 4'(m_rnd) : 4'd0), m_run, m_run,
          m_done, m_err, 4'(m_eidx)};
    checks++;
    if (outv() !== ex) begin
      failures++;
      $display("FAIL model_cycle t=%0t got=%h exp=%h",
               $time, outv(), ex);
    end
    if (rst_n) begin
      e = enc_m(bus.ack);
      if (m_run) begin
        if (!bus.stall) begin
          if (e == m_rnd) begin
            if (m_rnd == NR - 1) begin
              m_run = 0; m_done = 1;
            end else m_rnd++;
          end else begin
            m_run = 0; m_err = 1; m_eidx = e;
          end
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (bus.start) begin
        m_run = 1; m_rnd = 0; m_err = 0; m_eidx = 0;
      end
    end
  end

  task automatic run_seq(
    input int stall_idx, input int stall_len,
    input int bad_idx, input logic [NR-1:0] bad_ack,
    input int start_idx, input int rst_idx,
    input bit start_in_done,
    output int lat, output int hold4, output int nbusy
  );
    int stalled;
    bit ended;
    stalled = 0; lat = -1; hold4 = 0;
    nbusy = 0; ended = 0;
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    chk("run_entry", {bus.Din, bus.SD11, bus.err},
        {1'b1, 4'd0, 1'b0});
    for (int c = 1; c <= 40 && !ended; c++) begin
      bus.stall = 1'b0;
      bus.start = 1'b0;
      force_en  = 1'b0;
      if (bus.busy) nbusy++;
      if (bus.done) begin
        lat = c; ended = 1;
        if (start_in_done) bus.start = 1'b1;
      end else if (bus.err) begin
        ended = 1;
      end else if (bus.Din) begin
        if (bus.SD11 == 4'd4) hold4++;
        if (int'(bus.SD11) == stall_idx &&
            stalled < stall_len) begin
          bus.stall = 1'b1;
          stalled++;
        end
        if (int'(bus.SD11) == bad_idx) begin
          force_en  = 1'b1;
          force_val = bad_ack;
        end
        if (int'(bus.SD11) == start_idx) bus.start = 1'b1;
        if (int'(bus.SD11) == rst_idx) begin
          rst_n = 1'b0;
          #1 chk("reset_async", int'(outv()), 0);
          ended = 1;
        end
      end
      if (!ended) begin
        @(posedge clk); #1;
      end
    end
    chk("seq_bounded", int'(ended), 1);
  endtask

  int lat, h4, nb;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    force_en  = 1'b0;
    force_val = '0;
    #3 chk("reset_vals", int'(outv()), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 chk("idle_after_reset", int'(outv()), 0);

    run_seq(-1, 0, -1, '0, -1, -1, 0, lat, h4, nb);
    chk("lat_plain", lat, 12);
    chk("busy_plain", nb, 11);

    run_seq(4, 3, -1, '0, -1, -1, 0, lat, h4, nb);
    chk("lat_stall", lat, 15);
    chk("hold4_stall", h4, 4);
    chk("busy_stall", nb, 14);

    run_seq(-1, 0, 6, 11'b000_0010_0000, -1, -1, 0,
            lat, h4, nb);
    force_en = 1'b0;
    chk("err_flag", int'(bus.err), 1);
    chk("err_idx_5", int'(bus.err_idx), 5);
    chk("err_din", int'(bus.Din), 0);
    chk("err_no_done", lat, -1);

    run_seq(-1, 0, -1, '0, -1, -1, 0, lat, h4, nb);
    chk("lat_after_err", lat, 12);

    run_seq(-1, 0, 2, 11'b0, -1, -1, 0, lat, h4, nb);
    force_en = 1'b0;
    chk("err_idx_zero", int'(bus.err_idx), 15);

    run_seq(-1, 0, 2, 11'b000_0000_1100, -1, -1, 0,
            lat, h4, nb);
    force_en = 1'b0;
    chk("err_idx_multi", int'(bus.err_idx), 15);

    run_seq(-1, 0, -1, '0, 3, -1, 1, lat, h4, nb);
    chk("lat_start_in_run", lat, 12);
    @(posedge clk); #1 bus.start = 1'b0;
    chk("done_start_ignored", int'(outv()), 0);

    run_seq(-1, 0, -1, '0, -1, 7, 0, lat, h4, nb);
    chk("reset_no_done", lat, -1);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 chk("idle_after_abort", int'(outv()), 0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
